vga_pattern_gen: RTL and testbench

Self-timed, parametrised VGA test-pattern source for the DE2-115 video path. Generates horizontal/vertical timing internally from porch/sync parameters, produces one of four run-time-selectable patterns at configurable colour depth, and drives the ADV7123 DAC interface. All outputs are registered and mutually aligned.

---
 rtl/vga_pattern_gen.sv | 188 ++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
//------------------------------------------------------------------------------
// Module      : vga_pattern_gen
// Description : Self-timed VGA test-pattern source. Internal h/v timing from
//               porch/sync parameters, four run-time patterns (XOR/sum, colour
//               bars, checkerboard, grey ramp) at CW bits per channel, outputs
//               registered with one clock of latency and mutually aligned.
//               Optional feature macro: VGA_PATTERN_SCROLL_EN (adds an 8-bit
//               frame counter that scrolls modes 0 and 2 one pixel per frame).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CW       = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      mode,
    output logic            blank_n,
    output logic            hs,
    output logic            vs,
    output logic            sync_n,
    output logic [3*CW-1:0] rgb,
    output logic            frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    // Working width for pixel arithmetic: wide enough for x+fc and bit 5
    localparam int XW      = ((HW > VW) ? HW : VW) + 9;
    localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? (H_ACTIVE / 8) : 1;

    localparam logic [HW-1:0] C_H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] C_H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] C_HS_START   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] C_HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] C_BAR_W      = HW'(BAR_W);
    localparam logic [HW-1:0] C_BAR_MAX    = HW'(7);
    localparam logic [VW-1:0] C_V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] C_V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] C_VS_START   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] C_VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0]   h_q, h_d;
    logic [VW-1:0]   v_q, v_d;
    logic [1:0]      mode_q, mode_d;
    logic            blank_n_q, blank_n_d;
    logic            hs_q, hs_d;
    logic            vs_q, vs_d;
    logic            frame_start_q, frame_start_d;
    logic [3*CW-1:0] rgb_q, rgb_d;

    logic            w_frame_top;
    logic            w_active;
    logic [XW-1:0]   w_x;
    logic [XW-1:0]   w_y;
    logic [HW-1:0]   w_bar_full;
    logic [2:0]      w_bar;
    logic [2:0]      w_bar_rgb;
    logic [CW-1:0]   w_r, w_g, w_b;

`ifdef VGA_PATTERN_SCROLL_EN
    logic [7:0]      fc_q, fc_d;

    // Frame counter advances on the vertical wrap
    always_comb begin
        fc_d = fc_q;
        if (h_q == C_H_LAST && v_q == C_V_LAST) begin
            fc_d = fc_q + 8'd1;
        end
    end

    // Frame counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fc_q <= '0;
        else      fc_q <= fc_d;
    end

    assign w_x = XW'(h_q) + XW'(fc_q);
`else
    assign w_x = XW'(h_q);
`endif
    assign w_y = XW'(v_q);

    // Raster counters and frame-aligned mode selection
    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == C_H_LAST) begin
            h_d = '0;
            v_d = (v_q == C_V_LAST) ? '0 : v_q + 1'b1;
        end
        w_frame_top = (h_q == '0) && (v_q == '0);
        // The pixel at (0,0) already uses the newly sampled mode
        mode_d      = w_frame_top ? mode : mode_q;
    end

    // Pattern generation and timing outputs for the current (h,v)
    always_comb begin
        w_active   = (h_q < C_H_ACT) && (v_q < C_V_ACT);
        w_bar_full = h_q / C_BAR_W;
        w_bar      = (w_bar_full > C_BAR_MAX) ? 3'd7 : w_bar_full[2:0];
        case (w_bar)
            3'd0:    w_bar_rgb = 3'b111;   // white
            3'd1:    w_bar_rgb = 3'b110;   // yellow
            3'd2:    w_bar_rgb = 3'b011;   // cyan
            3'd3:    w_bar_rgb = 3'b010;   // green
            3'd4:    w_bar_rgb = 3'b101;   // magenta
            3'd5:    w_bar_rgb = 3'b100;   // red
            3'd6:    w_bar_rgb = 3'b001;   // blue
            default: w_bar_rgb = 3'b000;   // black
        endcase

        w_r = '0;
        w_g = '0;
        w_b = '0;
        case (mode_d)
            2'd0: begin
                w_r = CW'(w_x ^ w_y);
                w_g = CW'(w_x + w_y);
            end
            2'd1: begin
                w_r = {CW{w_bar_rgb[2]}};
                w_g = {CW{w_bar_rgb[1]}};
                w_b = {CW{w_bar_rgb[0]}};
            end
            2'd2: begin
                w_r = {CW{w_x[5] ^ w_y[5]}};
                w_g = w_r;
                w_b = w_r;
            end
            default: begin
                w_r = CW'(v_q);
                w_g = w_r;
                w_b = w_r;
            end
        endcase

        rgb_d         = w_active ? {w_r, w_g, w_b} : '0;
        blank_n_d     = w_active;
        hs_d          = !((h_q >= C_HS_START) && (h_q < C_HS_END));
        vs_d          = !((v_q >= C_VS_START) && (v_q < C_VS_END));
        frame_start_d = w_frame_top;
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q           <= '0;
            v_q           <= '0;
            mode_q        <= '0;
            blank_n_q     <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            frame_start_q <= 1'b0;
            rgb_q         <= '0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            mode_q        <= mode_d;
            blank_n_q     <= blank_n_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            frame_start_q <= frame_start_d;
            rgb_q         <= rgb_d;
        end
    end

    assign blank_n     = blank_n_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign sync_n      = 1'b0;   // sync-on-green not used
    assign rgb         = rgb_q;
    assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
//------------------------------------------------------------------------------
// Module      : tb_vga_pattern_gen
// Description : Self-checking bench for vga_pattern_gen. A reduced-raster
//               instance is compared every cycle against a pixel-arithmetic
//               reference model; a default-parameter instance is spot-checked.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vga_pattern_gen;

    localparam int HA  = 64;
    localparam int HFP = 4;
    localparam int HSY = 8;
    localparam int HBP = 4;
    localparam int VA  = 48;
    localparam int VFP = 2;
    localparam int VSY = 2;
    localparam int VBP = 4;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int FR  = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [1:0]  mode_def = 2'd0;

    logic        blank_n, hs, vs, sync_n, frame_start;
    logic [23:0] rgb;
    logic        d_blank_n, d_hs, d_vs, d_sync_n, d_frame_start;
    logic [23:0] d_rgb;

    int n_checks = 0;
    int n_pass   = 0;
    int k        = 0;
    int cur_mode = 0;
    bit def_phase = 1'b0;

    logic [23:0] bar_col [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    int sched [4] = '{1, 0, 2, 3};

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .CW(8)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .blank_n(blank_n), .hs(hs), .vs(vs), .sync_n(sync_n),
        .rgb(rgb), .frame_start(frame_start)
    );

    vga_pattern_gen dut_def (
        .clk(clk), .rst(rst), .mode(mode_def),
        .blank_n(d_blank_n), .hs(d_hs), .vs(d_vs), .sync_n(d_sync_n),
        .rgb(d_rgb), .frame_start(d_frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s (k=%0d): got %h expected %h", tag, k, got, exp);
    endtask

    // Expected colour for a pixel straight from the pattern definitions
    function automatic logic [23:0] exp_rgb(input int h, input int v, input int m, input int fc);
        int xs, r, g, b, bar;
        if (h >= HA || v >= VA) return 24'h0;
        xs = h + fc;
        r = 0; g = 0; b = 0;
        case (m)
            0: begin r = (xs ^ v) & 255; g = (xs + v) & 255; end
            1: begin
                bar = h / (HA / 8);
                if (bar > 7) bar = 7;
                return bar_col[bar];
            end
            2: return ((((xs >> 5) ^ (v >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            default: begin r = v & 255; g = r; b = r; end
        endcase
        return 24'((r << 16) | (g << 8) | b);
    endfunction

    // Expected {blank_n, hs, vs, sync_n, frame_start}
    function automatic logic [4:0] exp_ctl(input int h, input int v);
        logic bl, hv, vv, fs;
        bl = (h < HA) && (v < VA);
        hv = !((h >= HA + HFP) && (h < HA + HFP + HSY));
        vv = !((v >= VA + VFP) && (v < VA + VFP + VSY));
        fs = (h == 0) && (v == 0);
        return {bl, hv, vv, 1'b0, fs};
    endfunction

    task automatic check_reset();
        check("rst_rgb", 32'(rgb), 32'h0);
        check("rst_ctl", 32'({blank_n, hs, vs, sync_n, frame_start}), 32'h0C);
        check("rst_def_ctl", 32'({d_blank_n, d_hs, d_vs, d_sync_n, d_frame_start}), 32'h0C);
    endtask

    // One clock: check outputs after the edge, then drive stimulus on the falling edge
    task automatic step();
        int p, h, v, fc, f, pos;
        @(posedge clk);
        #1;
        k++;
        p = k - 1;
        h = p % HT;
        v = (p / HT) % VT;
        if (h == 0 && v == 0) cur_mode = int'(mode);
`ifdef VGA_PATTERN_SCROLL_EN
        fc = (p / FR) % 256;
`else
        fc = 0;
`endif
        check("rgb", 32'(rgb), 32'(exp_rgb(h, v, cur_mode, fc)));
        check("ctl", 32'({blank_n, hs, vs, sync_n, frame_start}), 32'(exp_ctl(h, v)));
        if (def_phase) begin
            case (k)
                1:    check("def_first_px", 32'({d_blank_n, d_frame_start}), 32'h3);
                640:  check("def_blank_640", 32'(d_blank_n), 32'h1);
                641:  check("def_blank_641", 32'(d_blank_n), 32'h0);
                656:  check("def_hs_656", 32'(d_hs), 32'h1);
                657:  check("def_hs_657", 32'(d_hs), 32'h0);
                752:  check("def_hs_752", 32'(d_hs), 32'h0);
                753:  check("def_hs_753", 32'(d_hs), 32'h1);
                1056: check("def_px_255_1", 32'(d_rgb), 32'hFE0000);
                1456: check("def_hs_1456", 32'(d_hs), 32'h1);
                1457: check("def_hs_1457", 32'(d_hs), 32'h0);
                4004: check("def_px_3_5", 32'(d_rgb), 32'h060800);
                default: ;
            endcase
        end
        f   = p / FR;
        pos = p % FR;
        @(negedge clk);
        if (pos == FR / 2) begin
            mode = (f < 4) ? 2'(sched[f]) : 2'($urandom_range(0, 3));
        end else if (f >= 5 && $urandom_range(0, 999) == 0) begin
            mode = 2'($urandom_range(0, 3));
        end
    endtask

    initial begin
        rst  = 1'b0;
        mode = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        @(negedge clk);
        rst = 1'b1;
        k = 0;
        cur_mode = 0;
        def_phase = 1'b1;
        repeat (4100) step();
        def_phase = 1'b0;
        repeat (9 * FR - 4100) step();
        repeat (FR / 3) step();

        // Mid-frame asynchronous reset held for three clocks
        #2;
        rst = 1'b0;
        #1;
        check_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            check_reset();
        end
        @(negedge clk);
        rst = 1'b1;
        k = 0;
        cur_mode = 0;
        repeat (2 * FR) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
